// File: rtl/bram_save_sequencer_if.sv
// ---------------------------------------------------------------------------
// bram_save_sequencer_if
// Groups the signals that pass between the save sequencer and the blocks it
// talks to: the HPS SD sector-request handshake and the port-B format-write
// bus into the backup RAM.
//
//   sd_lba   [31:0]  sector address             (sequencer -> HPS)
//   sd_rd            sector read request        (sequencer -> HPS)
//   sd_wr            sector write request       (sequencer -> HPS)
//   sd_ack           sector acknowledge         (HPS -> sequencer)
//   fmt_sel          port-B mux select          (sequencer -> RAM mux)
//   fmt_we           port-B write enable        (sequencer -> RAM)
//   fmt_addr [1:0]   format header word address (sequencer -> RAM)
//   fmt_data [15:0]  format header word data    (sequencer -> RAM)
//
// master: the sequencer side.  slave: the HPS / RAM side.
// ---------------------------------------------------------------------------
interface bram_save_sequencer_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        fmt_sel;
  logic        fmt_we;
  logic [1:0]  fmt_addr;
  logic [15:0] fmt_data;

  modport master (
    output sd_lba, sd_rd, sd_wr, fmt_sel, fmt_we, fmt_addr, fmt_data,
    input  sd_ack
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, fmt_sel, fmt_we, fmt_addr, fmt_data,
    output sd_ack
  );
endinterface

// File: rtl/bram_save_sequencer.sv
// ---------------------------------------------------------------------------
// bram_save_sequencer
// Moves save files between backup RAM port B and the HPS SD block interface,
// one 512-byte sector at a time, using a slot-based LBA.  Also writes the
// 4-word format header into backup RAM and holds the core in reset during a
// load or a format.
//
// Ports:
//   clk_sys        system clock
//   reset          asynchronous, active-high reset
//   download       ROM download active
//   img_mounted    one-cycle pulse: save image mounted
//   img_readonly   mounted image is read-only
//   img_size_nz    mounted image size is nonzero
//   slot           save slot, sampled when a transfer starts
//   load_req       level; rising edge starts a load
//   save_req       level; rising edge starts a save
//   format_req     level; rising edge starts a format
//   bram_wr        core write strobe to backup RAM (autosave builds only)
//   bk_ena         save image available
//   busy           transfer or format in progress
//   core_hold      core reset request
//   err            sticky ack-timeout flag
//   bus            SD handshake + format write bus (master modport)
//
// Optional feature: define BRAM_AUTOSAVE_EN to add an autosave that issues a
// save AS_DELAY quiet cycles after the last core write to backup RAM.
// ---------------------------------------------------------------------------
module bram_save_sequencer #(
  parameter int SECTORS  = 16,
  parameter int SLOT_W   = 2,
  parameter int TO_W     = 24,
  parameter int AS_DELAY = 1 << 22
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              download,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic              img_size_nz,
  input  logic [SLOT_W-1:0] slot,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              format_req,
  input  logic              bram_wr,
  output logic              bk_ena,
  output logic              busy,
  output logic              core_hold,
  output logic              err,
  bram_save_sequencer_if.master bus
);

  localparam int LOG2 = $clog2(SECTORS);
  // Counter value whose increment would reach all-ones: the timeout fires on
  // the cycle the counter arrives at 2^TO_W-1.
  localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}} - TO_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_FMT} state_t;

  state_t      state_q;
  logic [31:0] sd_lba_q;
  logic        sd_rd_q, sd_wr_q;
  logic        loading_q;
  logic [TO_W-1:0] to_q;
  logic        err_q;
  logic [1:0]  fmt_addr_q;
  logic        bk_ena_q;
  logic        dl_q;
  logic        ack_q;
  // Request levels are registered, then the edge is taken between two
  // registered copies, so a transfer starts 2 clocks after the input rises.
  logic [2:0]  req_q;      // {format, load, save}
  logic [2:0]  req_old_q;

  logic [2:0]  req_edge;
  logic        fmt_edge, load_edge, save_edge;
  logic        dl_rise, ack_rise, ack_fall;
  logic        mount_ok, idle;
  logic        start_fmt, start_load, start_save, start_auto;
  logic        as_fire;
  logic [31:0] lba_base;
  logic        last_sector;

  assign req_edge  = req_q & ~req_old_q;
  assign fmt_edge  = req_edge[2];
  assign load_edge = req_edge[1];
  assign save_edge = req_edge[0];

  // The ack is only compared against its own previous value, so an ack that
  // is already high when a transfer starts needs a fresh rising edge.
  assign dl_rise  = download & ~dl_q;
  assign ack_rise = bus.sd_ack & ~ack_q;
  assign ack_fall = ~bus.sd_ack & ack_q;
  assign mount_ok = download & img_mounted & img_size_nz & ~img_readonly;

  assign idle       = (state_q == S_IDLE);
  assign start_fmt  = idle & fmt_edge;
  assign start_load = idle & ~fmt_edge & load_edge & bk_ena_q;
  assign start_save = idle & ~fmt_edge & ~(load_edge & bk_ena_q) & save_edge & bk_ena_q;
  assign start_auto = idle & ~start_fmt & ~start_load & ~start_save & as_fire;

  assign lba_base    = 32'(slot) << LOG2;
  assign last_sector = &sd_lba_q[LOG2-1:0];

`ifdef BRAM_AUTOSAVE_EN
  localparam int AS_CW = $clog2(AS_DELAY + 1);

  logic             dirty_q;
  logic [AS_CW-1:0] as_cnt_q;

  // Each core write restarts the quiet period; the save fires only once the
  // RAM has been left alone for AS_DELAY cycles.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dirty_q  <= 1'b0;
      as_cnt_q <= '0;
    end else begin
      if (bram_wr) begin
        dirty_q  <= 1'b1;
        as_cnt_q <= AS_CW'(AS_DELAY);
      end else begin
        if (start_save | start_auto)
          dirty_q <= 1'b0;
        if (dirty_q && idle && as_cnt_q != '0)
          as_cnt_q <= as_cnt_q - AS_CW'(1);
      end
    end
  end

  assign as_fire = dirty_q & (as_cnt_q == '0) & bk_ena_q & ~download;
`else
  logic unused_bram_wr;
  assign unused_bram_wr = bram_wr;
  assign as_fire        = 1'b0;
`endif

  function automatic logic [15:0] fmt_word(input logic [1:0] a);
    case (a)
      2'd0:    fmt_word = 16'h5548;
      2'd1:    fmt_word = 16'h4D42;
      2'd2:    fmt_word = 16'h8800;
      default: fmt_word = 16'h8010;
    endcase
  endfunction

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sd_lba_q   <= '0;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 1'b0;
      loading_q  <= 1'b0;
      to_q       <= '0;
      err_q      <= 1'b0;
      fmt_addr_q <= '0;
      bk_ena_q   <= 1'b0;
      dl_q       <= 1'b0;
      ack_q      <= 1'b0;
      req_q      <= '0;
      req_old_q  <= '0;
    end else begin
      dl_q      <= download;
      ack_q     <= bus.sd_ack;
      req_q     <= {format_req, load_req, save_req};
      req_old_q <= req_q;

      // A mount in the same cycle as the download edge keeps the image.
      if (mount_ok)
        bk_ena_q <= 1'b1;
      else if (dl_rise)
        bk_ena_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start_fmt) begin
            fmt_addr_q <= '0;
            state_q    <= S_FMT;
          end else if (start_load | start_save | start_auto) begin
            sd_lba_q  <= lba_base;
            loading_q <= start_load;
            sd_rd_q   <= start_load;
            sd_wr_q   <= ~start_load;
            to_q      <= '0;
            err_q     <= 1'b0;
            state_q   <= S_REQ;
          end
        end

        S_REQ: begin
          if (dl_rise) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            state_q <= S_IDLE;
          end else if (ack_rise) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            state_q <= S_XFER;
          end else if (to_q == TO_LAST) begin
            to_q    <= '1;
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end

        S_XFER: begin
          if (dl_rise) begin
            state_q <= S_IDLE;
          end else if (ack_fall) begin
            if (last_sector) begin
              state_q <= S_IDLE;
            end else begin
              sd_lba_q <= sd_lba_q + 32'd1;
              sd_rd_q  <= loading_q;
              sd_wr_q  <= ~loading_q;
              to_q     <= '0;
              state_q  <= S_REQ;
            end
          end
        end

        default: begin // S_FMT
          if (dl_rise || fmt_addr_q == 2'd3) begin
            fmt_addr_q <= '0;
            state_q    <= S_IDLE;
          end else begin
            fmt_addr_q <= fmt_addr_q + 2'd1;
          end
        end
      endcase
    end
  end

  // Status and format-bus outputs are decodes of the state registers only.
  assign busy         = ~idle;
  assign core_hold    = (busy & loading_q) | (state_q == S_FMT);
  assign bk_ena       = bk_ena_q;
  assign err          = err_q;
  assign bus.sd_lba   = sd_lba_q;
  assign bus.sd_rd    = sd_rd_q;
  assign bus.sd_wr    = sd_wr_q;
  assign bus.fmt_sel  = (state_q == S_FMT);
  assign bus.fmt_we   = (state_q == S_FMT);
  assign bus.fmt_addr = fmt_addr_q;
  assign bus.fmt_data = (state_q == S_FMT) ? fmt_word(fmt_addr_q) : 16'h0000;

endmodule

// File: tb/tb_bram_save_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bram_save_sequencer
// Directed bench for bram_save_sequencer with SECTORS=16, SLOT_W=2, TO_W=4,
// AS_DELAY=100.  Inputs change 1 ns after a rising edge; outputs are sampled
// at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_bram_save_sequencer;
  localparam int SECTORS  = 16;
  localparam int SLOT_W   = 2;
  localparam int TO_W     = 4;
  localparam int AS_DELAY = 100;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              download = 1'b0;
  logic              img_mounted = 1'b0;
  logic              img_readonly = 1'b0;
  logic              img_size_nz = 1'b0;
  logic [SLOT_W-1:0] slot = '0;
  logic              load_req = 1'b0;
  logic              save_req = 1'b0;
  logic              format_req = 1'b0;
  logic              bram_wr = 1'b0;
  logic              bk_ena, busy, core_hold, err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  bram_save_sequencer_if bif ();

  bram_save_sequencer #(
    .SECTORS(SECTORS), .SLOT_W(SLOT_W), .TO_W(TO_W), .AS_DELAY(AS_DELAY)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .download(download),
    .img_mounted(img_mounted), .img_readonly(img_readonly),
    .img_size_nz(img_size_nz), .slot(slot), .load_req(load_req),
    .save_req(save_req), .format_req(format_req), .bram_wr(bram_wr),
    .bk_ena(bk_ena), .busy(busy), .core_hold(core_hold), .err(err),
    .bus(bif)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Mount pulse while download is high.
  task automatic mount(input logic ro);
    download     = 1'b1;
    img_size_nz  = 1'b1;
    img_readonly = ro;
    img_mounted  = 1'b1;
    tick();
    img_mounted  = 1'b0;
    tick();
  endtask

  // Ack rises, DUT enters XFER, ack falls, next request (if any) follows.
  task automatic ack_pulse();
    bif.sd_ack = 1'b1;
    tick(2);
    bif.sd_ack = 1'b0;
    tick();
  endtask

  logic [15:0] fmt_exp [4];
  int k;

  initial begin
    fmt_exp[0] = 16'h5548; fmt_exp[1] = 16'h4D42;
    fmt_exp[2] = 16'h8800; fmt_exp[3] = 16'h8010;
    bif.sd_ack = 1'b0;

    // ---- reset state
    tick(2);
    check("rst_sd_rd", bif.sd_rd, 0);
    check("rst_sd_wr", bif.sd_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_bk_ena", bk_ena, 0);
    check("rst_fmt_data", bif.fmt_data, 0);
    check("rst_fmt_we", bif.fmt_we, 0);
    reset = 1'b0;
    tick();

    // ---- bk_ena
    mount(1'b0);
    check("bk_ena_mount", bk_ena, 1);
    download = 1'b0; tick();
    download = 1'b1; tick();
    check("bk_ena_dl_rise", bk_ena, 0);
    mount(1'b1);
    check("bk_ena_ro", bk_ena, 0);
    mount(1'b0);
    check("bk_ena_remount", bk_ena, 1);
    download = 1'b0; tick();

    // ---- load, slot 2: 16 sectors from LBA 32
    slot = 2'd2;
    load_req = 1'b1;
    tick();
    check("load_lat1_rd", bif.sd_rd, 0);
    tick();
    check("load_lat2_rd", bif.sd_rd, 1);
    for (int i = 0; i < SECTORS; i++) begin
      check($sformatf("load_lba%0d", i), bif.sd_lba, 32 + i);
      check($sformatf("load_rd%0d", i), bif.sd_rd, 1);
      check($sformatf("load_wr%0d", i), bif.sd_wr, 0);
      check($sformatf("load_hold%0d", i), core_hold, 1);
      ack_pulse();
    end
    check("load_done_busy", busy, 0);
    check("load_done_rd", bif.sd_rd, 0);
    check("load_done_hold", core_hold, 0);
    load_req = 1'b0;
    tick(2);

    // ---- save + format together: format wins, save dropped
    save_req = 1'b1;
    format_req = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fmt_we%0d", i), bif.fmt_we, 1);
      check($sformatf("fmt_sel%0d", i), bif.fmt_sel, 1);
      check($sformatf("fmt_addr%0d", i), bif.fmt_addr, i);
      check($sformatf("fmt_data%0d", i), bif.fmt_data, fmt_exp[i]);
      check($sformatf("fmt_hold%0d", i), core_hold, 1);
      check($sformatf("fmt_wr%0d", i), bif.sd_wr, 0);
      tick();
    end
    check("fmt_end_we", bif.fmt_we, 0);
    check("fmt_end_busy", busy, 0);
    tick(3);
    check("fmt_save_dropped", bif.sd_wr, 0);
    save_req = 1'b0;
    format_req = 1'b0;
    tick(2);

    // ---- timeout: no ack, sd_wr high for 15 cycles
    slot = 2'd0;
    save_req = 1'b1;
    tick(2);
    check("to_start_wr", bif.sd_wr, 1);
    check("to_start_hold", core_hold, 0);
    tick(14);
    check("to_wr_c15", bif.sd_wr, 1);
    tick();
    check("to_wr_dropped", bif.sd_wr, 0);
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    save_req = 1'b0;
    tick(2);

    // ---- next save clears err; reset at sector 5
    slot = 2'd1;
    save_req = 1'b1;
    tick(2);
    check("save2_err_clr", err, 0);
    check("save2_wr", bif.sd_wr, 1);
    check("save2_lba", bif.sd_lba, 16);
    for (int i = 0; i < 5; i++) ack_pulse();
    check("save2_lba5", bif.sd_lba, 21);
    reset = 1'b1;
    save_req = 1'b0;
    #2;
    check("arst_wr", bif.sd_wr, 0);
    check("arst_busy", busy, 0);
    check("arst_lba", bif.sd_lba, 0);
    check("arst_bk_ena", bk_ena, 0);
    tick();
    reset = 1'b0;
    tick();

    // ---- download abort at sector 3
    mount(1'b0);
    download = 1'b0; tick();
    slot = 2'd0;
    save_req = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) ack_pulse();
    check("abort_lba3", bif.sd_lba, 3);
    bif.sd_ack = 1'b1;
    tick();
    check("abort_xfer_busy", busy, 1);
    download = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_wr", bif.sd_wr, 0);
    check("abort_err", err, 0);
    bif.sd_ack = 1'b0;
    tick();
    check("abort_late_busy", busy, 0);
    ack_pulse();
    check("abort_late2_busy", busy, 0);
    check("abort_late2_wr", bif.sd_wr, 0);
    save_req = 1'b0;
    tick(2);

    // ---- autosave
    mount(1'b0);
    download = 1'b0; tick();
`ifdef BRAM_AUTOSAVE_EN
    bram_wr = 1'b1; tick(); bram_wr = 1'b0;
    k = 1;
    while (!bif.sd_wr && k < 300) begin tick(); k++; end
    check("as1_started", (k >= 99 && k <= 104), 1);
    tick(20);
    check("as1_once", bif.sd_wr, 0);
    bram_wr = 1'b1; tick(); bram_wr = 1'b0;
    k = 1;
    tick(49); k += 49;
    bram_wr = 1'b1; tick(); bram_wr = 1'b0; k++;
    check("as2_not_yet", bif.sd_wr, 0);
    while (!bif.sd_wr && k < 400) begin tick(); k++; end
    check("as2_started", (k >= 149 && k <= 155), 1);
    tick(20);
`else
    bram_wr = 1'b1; tick(); bram_wr = 1'b0;
    tick(150);
    check("no_as_wr", bif.sd_wr, 0);
    check("no_as_busy", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
